// File: rtl/challenge_poly_mul.sv
// challenge_poly_mul: p = c * s mod (X^256 + 1, Q) for a sparse challenge c
// (coefficients in {0, 1, Q-1}) and one short polynomial s. Poly RAMs hold
// 4 coefficients per word. The optional centered-norm tracker is enabled by
// defining CHALLENGE_POLY_MUL_NORM_EN; otherwise norm_max is tied to zero.
module challenge_poly_mul #(
    parameter int N               = 256,
    parameter int Q               = 8380417,
    parameter int COEFF_WIDTH     = 24,
    parameter int WORD_LEN        = COEFF_WIDTH * 4,
    parameter int ADDR_POLY_WIDTH = $clog2(N * COEFF_WIDTH / WORD_LEN + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       done,
    output logic                       c_err,
    output logic [ADDR_POLY_WIDTH-1:0] addr_c,
    input  logic [WORD_LEN-1:0]        dout_c,
    output logic [ADDR_POLY_WIDTH-1:0] addr_s,
    input  logic [WORD_LEN-1:0]        dout_s,
    output logic                       we_p,
    output logic [ADDR_POLY_WIDTH-1:0] addr_p,
    output logic [WORD_LEN-1:0]        din_p,
    output logic [COEFF_WIDTH-1:0]     norm_max
);
    localparam int CW    = COEFF_WIDTH;
    localparam int WORDS = N * COEFF_WIDTH / WORD_LEN;
    localparam int CNT_W = $clog2(N) + 1;
    localparam logic [CW:0]   Q_EXT = (CW+1)'(Q);
    localparam logic [CW-1:0] Q_C   = CW'(Q);
    localparam logic [CW-1:0] Q_M1  = CW'(Q - 1);
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] ZERO  = CW'(0);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_WRITE, S_DONE} state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_inc_s;
    logic [2*N-1:0]     code_r;
    logic [CW-1:0]      sreg_r [N];
    logic [CW-1:0]      acc_r  [N];
    logic [7:0]         c_codes_s;
    logic               c_bad_s;

    // (a + b) mod Q for a, b in [0, Q)
    function automatic logic [CW-1:0] mod_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [CW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= Q_EXT) sum = sum - Q_EXT;
        else              sum = sum;
        return sum[CW-1:0];
    endfunction

    // (a - b) mod Q for a, b in [0, Q); a borrow shows up in the top bit
    function automatic logic [CW-1:0] mod_sub(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [CW:0] dif;
        dif = {1'b0, a} - {1'b0, b};
        if (dif[CW]) dif = dif + Q_EXT;
        else         dif = dif;
        return dif[CW-1:0];
    endfunction

    // -a mod Q, keeping zero at zero
    function automatic logic [CW-1:0] mod_neg(input logic [CW-1:0] a);
        return (a == ZERO) ? ZERO : (Q_C - a);
    endfunction

    // 2-bit code of a challenge coefficient: 01 = +1, 10 = -1, 00 otherwise
    function automatic logic [1:0] c_code(input logic [CW-1:0] v);
        logic [1:0] r;
        if (v == ONE)       r = 2'b01;
        else if (v == Q_M1) r = 2'b10;
        else                r = 2'b00;
        return r;
    endfunction

    // Coefficient outside {0, 1, Q-1}
    function automatic logic c_bad(input logic [CW-1:0] v);
        return (v != ZERO) && (v != ONE) && (v != Q_M1);
    endfunction

    assign cnt_inc_s = cnt_r + CNT_W'(1);

    // Decode the four c coefficients of the current RAM word
    always_comb begin
        c_codes_s = 8'h00;
        c_bad_s   = 1'b0;
        for (int m = 0; m < 4; m++) begin
            c_codes_s[2*m +: 2] = c_code(dout_c[m*CW +: CW]);
            c_bad_s             = c_bad_s | c_bad(dout_c[m*CW +: CW]);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= S_IDLE;
        else        state_r <= state_s;
    end

    // FSM next-state logic: fixed-length phases driven by cnt_r
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:  if (start) state_s = S_LOAD;
                     else       state_s = S_IDLE;
            S_LOAD:  if (cnt_r == CNT_W'(WORDS)) state_s = S_MAC;
                     else                        state_s = S_LOAD;
            S_MAC:   if (cnt_r == CNT_W'(N - 1)) state_s = S_WRITE;
                     else                        state_s = S_MAC;
            S_WRITE: if (cnt_r == CNT_W'(WORDS - 1)) state_s = S_DONE;
                     else                            state_s = S_WRITE;
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Datapath: load c codes and s, negacyclic multiply-accumulate, write back p
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            code_r <= '0;
            c_err  <= 1'b0;
            done   <= 1'b0;
            we_p   <= 1'b0;
            addr_c <= '0;
            addr_s <= '0;
            addr_p <= '0;
            din_p  <= '0;
            for (int i = 0; i < N; i++) begin
                acc_r[i]  <= ZERO;
                sreg_r[i] <= ZERO;
            end
        end else begin
            done <= 1'b0;
            we_p <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    addr_c <= '0;
                    addr_s <= '0;
                    addr_p <= '0;
                    din_p  <= '0;
                    if (start) begin
                        cnt_r <= '0;
                        c_err <= 1'b0;
                        for (int i = 0; i < N; i++) acc_r[i] <= ZERO;
                    end
                end
                S_LOAD: begin
                    // word cnt_r-1 is on the RAM outputs; shift it in at the top
                    if (cnt_r != '0) begin
                        code_r <= {c_codes_s, code_r[2*N-1:8]};
                        for (int i = 0; i < N - 4; i++) sreg_r[i] <= sreg_r[i+4];
                        for (int m = 0; m < 4; m++) sreg_r[N-4+m] <= dout_s[m*CW +: CW];
                        if (c_bad_s) c_err <= 1'b1;
                    end
                    if (cnt_r < CNT_W'(WORDS - 1)) begin
                        addr_c <= cnt_inc_s[ADDR_POLY_WIDTH-1:0];
                        addr_s <= cnt_inc_s[ADDR_POLY_WIDTH-1:0];
                    end else begin
                        addr_c <= '0;
                        addr_s <= '0;
                    end
                    cnt_r <= (cnt_r == CNT_W'(WORDS)) ? '0 : cnt_inc_s;
                end
                S_MAC: begin
                    // sreg holds s * X^j; add or subtract it according to code_j
                    for (int i = 0; i < N; i++) begin
                        case (code_r[1:0])
                            2'b01:   acc_r[i] <= mod_add(acc_r[i], sreg_r[i]);
                            2'b10:   acc_r[i] <= mod_sub(acc_r[i], sreg_r[i]);
                            default: acc_r[i] <= acc_r[i];
                        endcase
                    end
                    sreg_r[0] <= mod_neg(sreg_r[N-1]);
                    for (int i = 1; i < N; i++) sreg_r[i] <= sreg_r[i-1];
                    code_r <= {2'b00, code_r[2*N-1:2]};
                    cnt_r  <= (cnt_r == CNT_W'(N - 1)) ? '0 : cnt_inc_s;
                end
                S_WRITE: begin
                    // emit the lowest four accumulators and shift the rest down
                    we_p   <= 1'b1;
                    addr_p <= cnt_r[ADDR_POLY_WIDTH-1:0];
                    for (int m = 0; m < 4; m++) din_p[m*CW +: CW] <= acc_r[m];
                    for (int i = 0; i < N - 4; i++) acc_r[i] <= acc_r[i+4];
                    for (int i = N - 4; i < N; i++) acc_r[i] <= ZERO;
                    cnt_r <= (cnt_r == CNT_W'(WORDS - 1)) ? '0 : cnt_inc_s;
                end
                S_DONE: begin
                    done   <= 1'b1;
                    addr_p <= '0;
                    din_p  <= '0;
                    cnt_r  <= '0;
                end
                default: cnt_r <= '0;
            endcase
        end
    end

`ifdef CHALLENGE_POLY_MUL_NORM_EN
    localparam logic [CW-1:0] HALF = CW'((Q - 1) / 2);

    logic [CW-1:0] norm_r, norm_s;

    // Centered magnitude of a coefficient in [0, Q)
    function automatic logic [CW-1:0] center_abs(input logic [CW-1:0] a);
        return (a <= HALF) ? a : (Q_C - a);
    endfunction

    // Running maximum including the four coefficients being written this cycle
    always_comb begin
        norm_s = norm_r;
        for (int m = 0; m < 4; m++) begin
            if (center_abs(acc_r[m]) > norm_s) norm_s = center_abs(acc_r[m]);
            else                               norm_s = norm_s;
        end
    end

    // Norm register: cleared by an accepted start, updated during WRITE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              norm_r <= ZERO;
        else if (state_r == S_IDLE && start)     norm_r <= ZERO;
        else if (state_r == S_WRITE)             norm_r <= norm_s;
    end

    assign norm_max = norm_r;
`else
    assign norm_max = ZERO;
`endif

endmodule

// File: tb/tb_challenge_poly_mul.sv
// Directed self-checking bench for challenge_poly_mul.
module tb_challenge_poly_mul;
    localparam int Q = 8380417;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        done, c_err, we_p;
    logic [6:0]  addr_c, addr_s, addr_p;
    logic [95:0] dout_c, dout_s, din_p;
    logic [23:0] norm_max;

    logic [95:0] c_mem [128];
    logic [95:0] s_mem [128];
    logic [95:0] p_mem [128];
    int          wr_cnt = 0;

    int          checks = 0;
    int          errors = 0;
    int          c_co [256];
    int          s_co [256];
    logic [23:0] e_p  [256];

    challenge_poly_mul dut (
        .clk(clk), .rst_n(rst_n), .start(start), .done(done), .c_err(c_err),
        .addr_c(addr_c), .dout_c(dout_c), .addr_s(addr_s), .dout_s(dout_s),
        .we_p(we_p), .addr_p(addr_p), .din_p(din_p), .norm_max(norm_max)
    );

    always #5 clk = ~clk;

    // RAM models: 1-cycle read latency, write port for p
    always @(posedge clk) begin
        dout_c <= c_mem[addr_c];
        dout_s <= s_mem[addr_s];
        if (we_p) begin
            p_mem[addr_p] <= din_p;
            wr_cnt        <= wr_cnt + 1;
        end
    end

    task automatic clear_co();
        for (int i = 0; i < 256; i++) begin
            c_co[i] = 0;
            s_co[i] = 0;
        end
    endtask

    task automatic load_mems();
        for (int w = 0; w < 64; w++) begin
            for (int m = 0; m < 4; m++) begin
                c_mem[w][m*24 +: 24] = 24'(c_co[4*w+m]);
                s_mem[w][m*24 +: 24] = 24'(s_co[4*w+m]);
            end
        end
    endtask

    // Schoolbook negacyclic product; c values other than 1 and Q-1 count as 0
    task automatic ref_model();
        longint acc [256];
        for (int k = 0; k < 256; k++) acc[k] = 0;
        for (int j = 0; j < 256; j++) begin
            longint sgn;
            sgn = (c_co[j] == 1) ? 1 : ((c_co[j] == Q - 1) ? -1 : 0);
            for (int i = 0; i < 256; i++) begin
                int k;
                longint sg;
                k  = i + j;
                sg = sgn;
                if (k >= 256) begin
                    k  = k - 256;
                    sg = -sgn;
                end
                acc[k] = acc[k] + sg * longint'(s_co[i]);
            end
        end
        for (int k = 0; k < 256; k++) e_p[k] = 24'(((acc[k] % Q) + Q) % Q);
    endtask

    task automatic run_op(input int extra_at, output int lat);
        int cyc;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 1000) begin
            start = (cyc == extra_at) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        lat = cyc;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({done, c_err, we_p, addr_c, addr_s, addr_p, din_p, norm_max} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got done=%b c_err=%b we_p=%b addr_c=%0d addr_s=%0d addr_p=%0d din_p=%h norm=%0d, required all zero",
                     done, c_err, we_p, addr_c, addr_s, addr_p, din_p, norm_max);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_identity();
        int lat, w0;
        clear_co();
        c_co[0] = 1;
        for (int i = 0; i < 256; i++) s_co[i] = int'($urandom_range(0, Q - 1));
        load_mems();
        w0 = wr_cnt;
        run_op(-1, lat);
        checks++;
        if (lat !== 386) begin errors++; $display("FAIL identity_latency: got %0d required 386", lat); end
        checks++;
        if (wr_cnt - w0 !== 64) begin errors++; $display("FAIL identity_writes: got %0d required 64", wr_cnt - w0); end
        checks++;
        if (c_err !== 1'b0) begin errors++; $display("FAIL identity_c_err: got %b required 0", c_err); end
        for (int w = 0; w < 64; w++) begin
            checks++;
            if (p_mem[w] !== s_mem[w]) begin
                errors++;
                $display("FAIL identity_word%0d: got %h required %h", w, p_mem[w], s_mem[w]);
            end
        end
    endtask

    task automatic test_neg_top();
        int lat;
        logic [95:0] exp_w;
        clear_co();
        c_co[255] = Q - 1;
        s_co[0]   = 1;
        load_mems();
        run_op(-1, lat);
        for (int w = 0; w < 64; w++) begin
            exp_w = (w == 63) ? {24'd8380416, 72'd0} : 96'd0;
            checks++;
            if (p_mem[w] !== exp_w) begin
                errors++;
                $display("FAIL neg_top_word%0d: got %h required %h", w, p_mem[w], exp_w);
            end
        end
    endtask

    task automatic test_wrap();
        int lat;
        logic [95:0] exp_w;
        clear_co();
        c_co[1]   = 1;
        s_co[255] = 5;
        load_mems();
        run_op(-1, lat);
        for (int w = 0; w < 64; w++) begin
            exp_w = (w == 0) ? {72'd0, 24'd8380412} : 96'd0;
            checks++;
            if (p_mem[w] !== exp_w) begin
                errors++;
                $display("FAIL wrap_word%0d: got %h required %h", w, p_mem[w], exp_w);
            end
        end
    endtask

    task automatic test_random();
        int lat, v;
        logic [95:0] exp_w;
        clear_co();
        for (int n = 0; n < 60; n++) c_co[$urandom_range(0, 255)] = ($urandom_range(0, 1) == 1) ? 1 : Q - 1;
        for (int i = 0; i < 256; i++) begin
            v = int'($urandom_range(0, 4)) - 2;
            s_co[i] = (v < 0) ? Q + v : v;
        end
        load_mems();
        ref_model();
        run_op(-1, lat);
        checks++;
        if (lat !== 386) begin errors++; $display("FAIL random_latency: got %0d required 386", lat); end
        for (int w = 0; w < 64; w++) begin
            exp_w = {e_p[4*w+3], e_p[4*w+2], e_p[4*w+1], e_p[4*w]};
            checks++;
            if (p_mem[w] !== exp_w) begin
                errors++;
                $display("FAIL random_word%0d: got %h required %h", w, p_mem[w], exp_w);
            end
        end
    endtask

    task automatic test_c_err();
        int lat;
        clear_co();
        c_co[0]  = 1;
        c_co[10] = 5;
        for (int i = 0; i < 256; i++) s_co[i] = int'($urandom_range(0, Q - 1));
        load_mems();
        run_op(-1, lat);
        checks++;
        if (c_err !== 1'b1) begin errors++; $display("FAIL c_err_set: got %b required 1", c_err); end
        for (int w = 0; w < 64; w++) begin
            checks++;
            if (p_mem[w] !== s_mem[w]) begin
                errors++;
                $display("FAIL c_err_word%0d: got %h required %h", w, p_mem[w], s_mem[w]);
            end
        end
    endtask

    task automatic test_zero_c();
        int lat, w0;
        clear_co();
        for (int i = 0; i < 256; i++) s_co[i] = int'($urandom_range(1, Q - 1));
        load_mems();
        w0 = wr_cnt;
        run_op(-1, lat);
        checks++;
        if (c_err !== 1'b0) begin errors++; $display("FAIL zero_c_err_cleared: got %b required 0", c_err); end
        checks++;
        if (wr_cnt - w0 !== 64) begin errors++; $display("FAIL zero_c_writes: got %0d required 64", wr_cnt - w0); end
        for (int w = 0; w < 64; w++) begin
            checks++;
            if (p_mem[w] !== 96'd0) begin
                errors++;
                $display("FAIL zero_c_word%0d: got %h required 0", w, p_mem[w]);
            end
        end
    endtask

    task automatic test_reset_mid_mac();
        int w0;
        logic saw_done;
        clear_co();
        c_co[10] = 5;
        s_co[3]  = 7;
        load_mems();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (70) @(posedge clk);
        #1;
        checks++;
        if (c_err !== 1'b1) begin errors++; $display("FAIL mid_c_err_after_load: got %b required 1", c_err); end
        repeat (80) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({done, c_err, we_p, addr_c, addr_s, addr_p, din_p, norm_max} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got done=%b c_err=%b we_p=%b din_p=%h, required all zero", done, c_err, we_p, din_p);
        end
        @(negedge clk);
        rst_n = 1'b1;
        w0 = wr_cnt;
        saw_done = 1'b0;
        repeat (400) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (wr_cnt - w0 !== 0 || saw_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_idle: got writes=%0d done_seen=%b required 0 and 0", wr_cnt - w0, saw_done);
        end
    endtask

    task automatic test_norm();
        int lat;
        logic [23:0] exp_norm;
        logic [95:0] exp_w;
`ifdef CHALLENGE_POLY_MUL_NORM_EN
        exp_norm = 24'd100;
`else
        exp_norm = 24'd0;
`endif
        clear_co();
        c_co[0] = 1;
        s_co[0] = Q - 100;
        s_co[1] = 57;
        load_mems();
        run_op(150, lat);
        checks++;
        if (lat !== 386) begin errors++; $display("FAIL norm_latency_start_in_mac: got %0d required 386", lat); end
        checks++;
        if (norm_max !== exp_norm) begin errors++; $display("FAIL norm_max: got %0d required %0d", norm_max, exp_norm); end
        for (int w = 0; w < 64; w++) begin
            exp_w = (w == 0) ? {48'd0, 24'd57, 24'd8380317} : 96'd0;
            checks++;
            if (p_mem[w] !== exp_w) begin
                errors++;
                $display("FAIL norm_word%0d: got %h required %h", w, p_mem[w], exp_w);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, w0;
        logic saw_done;
        clear_co();
        c_co[2] = 1;
        s_co[0] = 9;
        load_mems();
        run_op(385, lat);
        checks++;
        if (lat !== 386) begin errors++; $display("FAIL b2b_latency: got %0d required 386", lat); end
        w0 = wr_cnt;
        saw_done = 1'b0;
        repeat (400) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (wr_cnt - w0 !== 0 || saw_done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_start_in_done: got writes=%0d done_seen=%b required 0 and 0", wr_cnt - w0, saw_done);
        end
        run_op(-1, lat);
        checks++;
        if (lat !== 386) begin errors++; $display("FAIL b2b_restart_latency: got %0d required 386", lat); end
        checks++;
        if (p_mem[0] !== {24'd0, 24'd9, 48'd0}) begin
            errors++;
            $display("FAIL b2b_word0: got %h required %h", p_mem[0], {24'd0, 24'd9, 48'd0});
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_neg_top();
        test_wrap();
        test_random();
        test_c_err();
        test_zero_c();
        test_reset_mid_mac();
        test_norm();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
